// File: rtl/bist_pkg.sv
// March C- BIST shared definitions: FSM states, element and op encoding,
// per-element direction/data tables, default read latency.
package bist_pkg;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    E0, E1, E2, E3, E4, E5
  } elem_t;

  typedef enum logic {
    OP_R = 1'b0,
    OP_W = 1'b1
  } op_t;

  // E3/E4 walk LAST_ADDR..0, the rest walk 0..LAST_ADDR.
  function automatic logic elem_dn(elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  // E1..E4 are read-then-write pairs; E0 and E5 are single ops.
  function automatic logic elem_pair(elem_t e);
    return (e != E0) && (e != E5);
  endfunction

  function automatic op_t elem_op(elem_t e, logic ph);
    if (e == E0) return OP_W;
    if (e == E5) return OP_R;
    return ph ? OP_W : OP_R;
  endfunction

  // Background written by the element (E5 has none, 0 is used).
  function automatic logic elem_wbit(elem_t e);
    return (e == E1) || (e == E3);
  endfunction

  // Background expected by the element's read.
  function automatic logic elem_rbit(elem_t e);
    return (e == E2) || (e == E4);
  endfunction

  function automatic elem_t elem_next(elem_t e);
    return (e == E5) ? E5 : elem_t'(e + 3'd1);
  endfunction

endpackage

// File: rtl/bist_rd_cmp.sv
// Read compare pipe: RD_LAT-deep {valid, expected} shift register,
// comparator and sticky fail flag.
// Ports: clk, rst (sync, high), clr (restart), rd_issue, exp, rdata,
// fail (includes the compare in flight this cycle).
// BIST_DIAG_EN adds addr/elem inputs and first-fail capture + count.
module bist_rd_cmp
  import bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail
`ifdef BIST_DIAG_EN
  ,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  elem_t                 elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [15:0]           fail_cnt
`endif
);

  localparam int L = RD_LAT - 1;

  logic [RD_LAT-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] exp_q [RD_LAT];
  logic                  fail_q;
  logic                  miscmp;

  assign miscmp = vld_q[L] && (rdata != exp_q[L]);
  // Combinational OR so pass is already final in the cycle done rises.
  assign fail   = fail_q | miscmp;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q  <= '0;
      fail_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) exp_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_issue;
      exp_q[0] <= exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
      if (miscmp) fail_q <= 1'b1;
    end
  end

`ifdef BIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] addr_q [RD_LAT];
  elem_t                 elem_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      fail_cnt  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        elem_q[i] <= E0;
      end
    end else begin
      addr_q[0] <= addr;
      elem_q[0] <= elem;
      for (int i = 1; i < RD_LAT; i++) begin
        addr_q[i] <= addr_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
      if (miscmp) begin
        if (!fail_q) begin
          fail_addr <= addr_q[L];
          fail_elem <= elem_q[L];
          fail_exp  <= exp_q[L];
          fail_act  <= rdata;
        end
        if (fail_cnt != 16'hffff) fail_cnt <= fail_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller: FSM, element/op/address counters, wdata
// lookahead; read checking lives in bist_rd_cmp.
// Ports: clk, rst (sync, high), start, done, pass, write_read, address,
// wdata, rdata. BIST_DIAG_EN adds fail_addr/elem/exp/act/cnt.
module march_bist_ctrl
  import bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LAST_ADDR  = 255,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  pass,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
`ifdef BIST_DIAG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [15:0]           fail_cnt
`endif
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  state_t                state_q, state_d;
  elem_t                 elem_q, elem_d;
  logic                  ph_q, ph_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  clr;
  logic                  last_op;
  logic                  at_end;
  logic                  rd_issue;
  logic                  fail;
  op_t                   op;

  assign op      = elem_op(elem_q, ph_q);
  assign last_op = elem_pair(elem_q) ? ph_q : 1'b1;
  assign at_end  = elem_dn(elem_q) ? (addr_q == '0)
                                   : (addr_q == LAST);

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = E0;
          ph_d    = 1'b0;
          addr_d  = '0;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        if (!last_op) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!at_end) begin
            addr_d = elem_dn(elem_q) ? addr_q - 1'b1
                                     : addr_q + 1'b1;
          end else if (elem_q == E5) begin
            // done must rise RD_LAT cycles after this last read.
            state_d = (RD_LAT > 1) ? S_DRAIN : S_DONE;
            cnt_d   = CW'(RD_LAT - 1);
          end else begin
            elem_d = elem_next(elem_q);
            addr_d = elem_dn(elem_d) ? LAST : '0;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(1)) state_d = S_DONE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= E0;
      ph_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      ph_q    <= ph_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      // Every write in an element carries the same background, so
      // tracking the element keeps wdata one op ahead of each write.
      wdata_q <= {DATA_WIDTH{elem_wbit(elem_d)}};
    end
  end

  assign rd_issue   = (state_q == S_RUN) && (op == OP_R);
  assign write_read = (state_q == S_RUN) && (op == OP_W);
  assign address    = addr_q;
  assign wdata      = wdata_q;
  assign done       = (state_q == S_DONE);
  assign pass       = done & ~fail;

  bist_rd_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .rd_issue  (rd_issue),
    .exp       ({DATA_WIDTH{elem_rbit(elem_q)}}),
    .rdata     (rdata),
    .fail      (fail)
`ifdef BIST_DIAG_EN
    ,
    .addr      (addr_q),
    .elem      (elem_q),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act),
    .fail_cnt  (fail_cnt)
`endif
  );

endmodule
